// File: rtl/ldl_arb_pkg.sv
// Shared arbitration types and the round-robin pick helper.
package ldl_arb_pkg;

    localparam int unsigned PICK_MAXN = 256;
    localparam int unsigned PICK_IDW  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                found;
        logic [PICK_IDW-1:0] idx;
    } pick_t;

    // First set request at or after ptr, wrapping at n; never returns idx >= n.
    function automatic pick_t rr_pick(input logic [PICK_MAXN-1:0] req,
                                      input logic [PICK_IDW-1:0]  ptr,
                                      input int unsigned          n);
        pick_t       res;
        logic [31:0] idx;
        res = '0;
        for (int unsigned k = 0; k < PICK_MAXN; k++) begin
            if (k < n) begin
                idx = 32'(ptr) + 32'(k);
                if (idx >= 32'(n)) begin
                    idx = idx - 32'(n);
                end
                if (!res.found && req[idx[PICK_IDW-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = idx[PICK_IDW-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ldl_bin2hot.sv
// Binary-to-one-hot decoder with enable; all-zero output when disabled.
module ldl_bin2hot #(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0]      bin,
    input  logic                  en,
    output logic [2**WIDTH-1:0]   hot_c
);

    // Decode the binary index into a single set bit.
    always_comb begin
        hot_c = '0;
        if (en) begin
            hot_c[bin] = 1'b1;
        end
    end

endmodule

// File: rtl/ldl_rr_arbiter.sv
// Round-robin arbiter with grant hold, optional hold limit and forced-release pulse.
module ldl_rr_arbiter
    import ldl_arb_pkg::*;
#(
    parameter int unsigned  N        = 4,
    localparam int unsigned IDW      = $clog2(N),
    parameter int unsigned  HOLD_MAX = 0,
    parameter int unsigned  CW       = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [N-1:0]   req,
    input  logic           rel,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_vld,
    output logic           forced
);

    localparam int unsigned HOTW = 2**IDW;

    arb_state_e     state, state_n;
    logic [IDW-1:0] ptr, ptr_n, gnt_id_n;
    logic [CW-1:0]  hold_cnt, hold_n;
    logic           vld_n, forced_n;

    logic [N-1:0]   owner_mask_c;
    logic           own_req_c;
    logic           expire_c;
    logic           rel_ev_c;
    logic [IDW-1:0] next_ptr_c;
    logic [IDW-1:0] scan_ptr_c;
    logic [N-1:0]   cand_c;
    pick_t          pick_c;
    logic [HOTW-1:0] hot_c;

    // Release detection and the candidate set / scan start for this cycle's pick.
    always_comb begin
        owner_mask_c = N'(1) << gnt_id;
        own_req_c    = |(req & owner_mask_c);
        expire_c     = (HOLD_MAX != 0) && (hold_cnt == CW'(HOLD_MAX));
        rel_ev_c     = (state == OWN) && (rel || !own_req_c || expire_c);
        next_ptr_c   = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + IDW'(1);
        scan_ptr_c   = rel_ev_c ? next_ptr_c : ptr;
        cand_c       = rel_ev_c ? (req & ~owner_mask_c) : req;
        pick_c       = rr_pick(PICK_MAXN'(cand_c), PICK_IDW'(scan_ptr_c), N);
    end

    // Next-state, grant and hold-counter logic.
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        gnt_id_n = gnt_id;
        vld_n    = gnt_vld;
        hold_n   = hold_cnt;
        forced_n = 1'b0;
        case (state)
            IDLE: begin
                if (en && pick_c.found) begin
                    state_n  = OWN;
                    gnt_id_n = IDW'(pick_c.idx);
                    vld_n    = 1'b1;
                    hold_n   = CW'(1);
                end
            end
            OWN: begin
                if (rel_ev_c) begin
                    ptr_n    = next_ptr_c;
                    forced_n = expire_c && !rel && own_req_c;
                    if (en && pick_c.found) begin
                        gnt_id_n = IDW'(pick_c.idx);
                        hold_n   = CW'(1);
                    end else begin
                        state_n = IDLE;
                        vld_n   = 1'b0;
                    end
                end else if (hold_cnt != '1) begin
                    hold_n = hold_cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                vld_n   = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt_id   <= '0;
            gnt_vld  <= 1'b0;
            hold_cnt <= '0;
            forced   <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            gnt_id   <= gnt_id_n;
            gnt_vld  <= vld_n;
            hold_cnt <= hold_n;
            forced   <= forced_n;
        end
    end

    ldl_bin2hot #(.WIDTH(IDW)) u_bin2hot (
        .bin   (gnt_id),
        .en    (gnt_vld),
        .hot_c (hot_c)
    );

    assign gnt = hot_c[N-1:0];

endmodule

// File: tb/tb_ldl_rr_arbiter.sv
// Self-checking bench: three arbiter configurations against a behavioural model.
module tb_ldl_rr_arbiter;

    typedef struct packed {
        int owner;   // -1 when no grant
        int ptr;
        int hold;
        bit forced;
    } mdl_t;

    logic clk, rst_n;

    logic       en_a, rel_a, vld_a, frc_a;
    logic [3:0] req_a, gnt_a;
    logic [1:0] id_a;

    logic       en_b, rel_b, vld_b, frc_b;
    logic [4:0] req_b, gnt_b;
    logic [2:0] id_b;

    logic       en_c, rel_c, vld_c, frc_c;
    logic [3:0] req_c, gnt_c;
    logic [1:0] id_c;

    int   n_checks = 0;
    int   n_errors = 0;
    mdl_t m [3];
    int   nn [3] = '{4, 5, 4};
    int   hm [3] = '{0, 0, 3};

    ldl_rr_arbiter #(.N(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .req(req_a), .rel(rel_a),
        .gnt(gnt_a), .gnt_id(id_a), .gnt_vld(vld_a), .forced(frc_a));

    ldl_rr_arbiter #(.N(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .req(req_b), .rel(rel_b),
        .gnt(gnt_b), .gnt_id(id_b), .gnt_vld(vld_b), .forced(frc_b));

    ldl_rr_arbiter #(.N(4), .HOLD_MAX(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en_c), .req(req_c), .rel(rel_c),
        .gnt(gnt_c), .gnt_id(id_c), .gnt_vld(vld_c), .forced(frc_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: one clock of the arbitration rules.
    function automatic mdl_t mdl_next(input mdl_t s, input int n, input int hmax,
                                      input logic [7:0] rq, input logic e, input logic rl);
        mdl_t r;
        int   excl;
        int   start;
        bit   try_pick;
        bit   drop;
        bit   expd;
        int   idx;
        r        = s;
        r.forced = 1'b0;
        excl     = -1;
        start    = s.ptr;
        try_pick = 1'b0;
        if (s.owner < 0) begin
            try_pick = e;
        end else begin
            drop = !rq[s.owner];
            expd = (hmax != 0) && (s.hold == hmax);
            if (rl || drop || expd) begin
                r.forced = expd && !rl && !drop;
                excl     = s.owner;
                start    = (s.owner + 1) % n;
                r.ptr    = start;
                r.owner  = -1;
                try_pick = e;
            end else begin
                r.hold = (s.hold < 65535) ? s.hold + 1 : s.hold;
            end
        end
        if (try_pick) begin
            for (int k = 0; k < n; k++) begin
                idx = (start + k) % n;
                if (r.owner < 0 && rq[idx] && idx != excl) begin
                    r.owner = idx;
                    r.hold  = 1;
                end
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input string tag, input int i, input logic [7:0] g,
                              input logic [7:0] id, input logic v, input logic f);
        logic [31:0] expg;
        expg = (m[i].owner < 0) ? 32'd0 : (32'd1 << m[i].owner);
        chk({tag, ".gnt"}, 32'(g), expg);
        chk({tag, ".gnt_vld"}, 32'(v), (m[i].owner < 0) ? 32'd0 : 32'd1);
        chk({tag, ".forced"}, 32'(f), 32'(m[i].forced));
        if (m[i].owner >= 0) chk({tag, ".gnt_id"}, 32'(id), 32'(m[i].owner));
    endtask

    task automatic check_all();
        check_inst("a", 0, 8'(gnt_a), 8'(id_a), vld_a, frc_a);
        check_inst("b", 1, 8'(gnt_b), 8'(id_b), vld_b, frc_b);
        check_inst("c", 2, 8'(gnt_c), 8'(id_c), vld_c, frc_c);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m[i] = '{owner: -1, ptr: 0, hold: 0, forced: 1'b0};
    endtask

    // Advance one clock: model from pre-edge inputs, sample outputs 1 time unit after the edge.
    task automatic tick();
        mdl_t na, nb, nc;
        na = mdl_next(m[0], nn[0], hm[0], 8'(req_a), en_a, rel_a);
        nb = mdl_next(m[1], nn[1], hm[1], 8'(req_b), en_b, rel_b);
        nc = mdl_next(m[2], nn[2], hm[2], 8'(req_c), en_c, rel_c);
        @(posedge clk);
        #1;
        m[0] = na;
        m[1] = nb;
        m[2] = nc;
        check_all();
    endtask

    initial begin
        logic [3:0] seq1 [3];
        seq1 = '{4'b0010, 4'b1000, 4'b0010};

        rst_n = 1'b0;
        en_a = 1'b0; rel_a = 1'b0; req_a = '0;
        en_b = 1'b0; rel_b = 1'b0; req_b = '0;
        en_c = 1'b0; rel_c = 1'b0; req_c = '0;
        model_reset();
        #12;
        chk("rst.gnt",    32'(gnt_a), 32'd0);
        chk("rst.gnt_id", 32'(id_a),  32'd0);
        chk("rst.vld",    32'(vld_a), 32'd0);
        chk("rst.forced", 32'(frc_a), 32'd0);
        rst_n = 1'b1;

        // 1: req=1010 held, release every third grant cycle.
        en_a = 1'b1; req_a = 4'b1010;
        tick();
        for (int g = 0; g < 3; g++) begin
            for (int c = 0; c < 3; c++) begin
                chk("t1.gnt", 32'(gnt_a), 32'(seq1[g]));
                chk("t1.gnt_id", 32'(id_a), (g == 1) ? 32'd3 : 32'd1);
                rel_a = (c == 2);
                tick();
                rel_a = 1'b0;
            end
        end

        // 2: all requesting, release every cycle, back-to-back rotation.
        req_a = 4'b0000;
        tick();
        req_a = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t2.gnt", 32'(gnt_a), 32'd1 << (k % 4));
            chk("t2.vld", 32'(vld_a), 32'd1);
            rel_a = 1'b1;
            tick();
        end
        rel_a = 1'b0;

        // 3: N=5, only requester 4, pointer wrap, then requester 0 wins.
        en_b = 1'b1; req_b = 5'b10000;
        tick();
        tick();
        chk("t3.gnt_id", 32'(id_b), 32'd4);
        rel_b = 1'b1;
        tick();
        rel_b = 1'b0;
        chk("t3.idle", 32'(gnt_b), 32'd0);
        tick();
        chk("t3.regrant", 32'(id_b), 32'd4);
        req_b = 5'b10001; rel_b = 1'b1;
        tick();
        rel_b = 1'b0;
        chk("t3.wrap", 32'(gnt_b), 32'b00001);

        // 4: HOLD_MAX=3, single holder, forced release then re-grant.
        en_c = 1'b1; req_c = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4.hold", 32'(gnt_c), 32'd1);
        end
        tick();
        chk("t4.drop", 32'(gnt_c), 32'd0);
        chk("t4.forced", 32'(frc_c), 32'd1);
        tick();
        chk("t4.regrant", 32'(gnt_c), 32'd1);
        chk("t4.pulse", 32'(frc_c), 32'd0);
        tick();
        tick();
        rel_c = 1'b1;
        tick();
        rel_c = 1'b0;
        chk("t4.relexp", 32'(frc_c), 32'd0);

        // 5: en low while owner 2 holds; no new grant until en returns.
        req_a = 4'b0000;
        tick();
        req_a = 4'b0100;
        tick();
        en_a = 1'b0; req_a = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5.kept", 32'(gnt_a), 32'b0100);
        end
        rel_a = 1'b1;
        tick();
        rel_a = 1'b0;
        chk("t5.rel", 32'(gnt_a), 32'd0);
        tick();
        chk("t5.noen", 32'(gnt_a), 32'd0);
        en_a = 1'b1;
        tick();
        chk("t5.en", 32'(gnt_a), 32'b0001);

        // 6: asynchronous reset between edges, then lowest active index wins.
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.gnt",    32'(gnt_a), 32'd0);
        chk("t6.vld",    32'(vld_a), 32'd0);
        chk("t6.gnt_id", 32'(id_a),  32'd0);
        chk("t6.b.vld",  32'(vld_b), 32'd0);
        chk("t6.c.vld",  32'(vld_c), 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        req_a = 4'b0110;
        tick();
        chk("t6.first", 32'(gnt_a), 32'b0010);

        // Randomized traffic on all three instances against the model.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) req_a = 4'($urandom);
            if ($urandom_range(0, 2) == 0) req_b = 5'($urandom);
            if ($urandom_range(0, 2) == 0) req_c = 4'($urandom);
            en_a  = ($urandom_range(0, 7) != 0);
            en_b  = ($urandom_range(0, 7) != 0);
            en_c  = ($urandom_range(0, 7) != 0);
            rel_a = ($urandom_range(0, 3) == 0);
            rel_b = ($urandom_range(0, 3) == 0);
            rel_c = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
